// File: rtl/regex_lit_matcher.sv
// ============================================================================
// regex_lit_matcher : multi-pattern literal byte-stream matcher (shift-and NFA)
// Rev 1.0
// ============================================================================
`default_nettype none

module regex_lit_matcher #(
  parameter int NUM_PAT = 4,
  parameter int PAT_LEN = 8,
  parameter int OFF_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_pat,
  input  logic [4:0]          cfg_idx,
  input  logic [7:0]          cfg_byte,
  input  logic [5:0]          cfg_len,
  input  logic                cfg_nocase,
  output logic                cfg_err,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [NUM_PAT-1:0]  m_match,
  output logic [3:0]          m_first_pat,
  output logic [OFF_W-1:0]    m_offset
);

  function automatic logic [7:0] fold(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  logic               w_accept;
  logic               w_cfg_ok;
  logic               r_in_pkt;
  logic               r_cfg_err;
  logic [NUM_PAT-1:0] w_hit;
  logic               w_any;
  logic [3:0]         w_low;
  logic [3:0]         w_rec_pat;
  logic [OFF_W-1:0]   w_rec_off;
  logic [NUM_PAT-1:0] r_sticky;
  logic               r_have_first;
  logic [3:0]         r_first_pat;
  logic [OFF_W-1:0]   r_first_off;
  logic [OFF_W-1:0]   r_off;
  logic               r_m_valid;
  logic [NUM_PAT-1:0] r_m_match;
  logic [3:0]         r_m_first;
  logic [OFF_W-1:0]   r_m_off;

  assign s_ready  = ~r_m_valid | m_ready;
  assign w_accept = s_valid & s_ready;
  // Tables may only change between packets so in-flight NFA state stays coherent.
  assign w_cfg_ok = cfg_we & ~r_in_pkt
                  & ({28'd0, cfg_pat} < 32'(NUM_PAT))
                  & ({27'd0, cfg_idx} < 32'(PAT_LEN));

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
    logic [7:0]         r_tab [PAT_LEN];
    logic [5:0]         r_len;
    logic               r_nocase;
    logic [PAT_LEN-1:0] r_st;
    logic [PAT_LEN-1:0] w_eq;
    logic [PAT_LEN-1:0] w_st_nxt;
    logic               w_hit_p;

    // A hit of length L is exactly the next-state bit L-1; lengths above PAT_LEN never hit.
    always_comb begin
      w_eq     = '0;
      w_st_nxt = '0;
      w_hit_p  = 1'b0;
      for (int k = 0; k < PAT_LEN; k++)
        w_eq[k] = r_nocase ? (fold(s_data) == fold(r_tab[k])) : (s_data == r_tab[k]);
      w_st_nxt[0] = w_eq[0];
      for (int k = 1; k < PAT_LEN; k++)
        w_st_nxt[k] = r_st[k-1] & w_eq[k];
      for (int k = 0; k < PAT_LEN; k++)
        if (r_len == 6'(k + 1)) w_hit_p = w_st_nxt[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_len    <= '0;
        r_nocase <= 1'b0;
        r_st     <= '0;
        for (int k = 0; k < PAT_LEN; k++) r_tab[k] <= '0;
      end else begin
        if (w_cfg_ok && cfg_pat == 4'(p)) begin
          r_len    <= cfg_len;
          r_nocase <= cfg_nocase;
          for (int k = 0; k < PAT_LEN; k++)
            if (cfg_idx == 5'(k)) r_tab[k] <= cfg_byte;
        end
        if (w_accept) r_st <= s_last ? '0 : w_st_nxt;
      end
    end

    assign w_hit[p] = w_hit_p;
  end

  always_comb begin
    w_low = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--)
      if (w_hit[i]) w_low = 4'(i);
  end

  assign w_any     = |w_hit;
  assign w_rec_pat = r_have_first ? r_first_pat : (w_any ? w_low : 4'd0);
  assign w_rec_off = r_have_first ? r_first_off : (w_any ? r_off : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt     <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_sticky     <= '0;
      r_have_first <= 1'b0;
      r_first_pat  <= '0;
      r_first_off  <= '0;
      r_off        <= '0;
      r_m_valid    <= 1'b0;
      r_m_match    <= '0;
      r_m_first    <= '0;
      r_m_off      <= '0;
    end else begin
      r_cfg_err <= cfg_we & ~w_cfg_ok;
      if (w_accept) begin
        if (s_last) begin
          r_in_pkt     <= 1'b0;
          r_sticky     <= '0;
          r_have_first <= 1'b0;
          r_first_pat  <= '0;
          r_first_off  <= '0;
          r_off        <= '0;
        end else begin
          r_in_pkt <= 1'b1;
          r_sticky <= r_sticky | w_hit;
          if (!r_have_first && w_any) begin
            r_have_first <= 1'b1;
            r_first_pat  <= w_low;
            r_first_off  <= r_off;
          end
          if (r_off != {OFF_W{1'b1}}) r_off <= r_off + 1'b1;
        end
      end
      if (w_accept && s_last) begin
        r_m_valid <= 1'b1;
        r_m_match <= r_sticky | w_hit;
        r_m_first <= w_rec_pat;
        r_m_off   <= w_rec_off;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign cfg_err     = r_cfg_err;
  assign m_valid     = r_m_valid;
  assign m_match     = r_m_match;
  assign m_first_pat = r_m_first;
  assign m_offset    = r_m_off;

endmodule

`default_nettype wire

// File: tb/tb_regex_lit_matcher.sv
// ============================================================================
// tb_regex_lit_matcher : directed bench with a substring-search reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regex_lit_matcher;

  typedef struct {
    logic [1:0]  m;
    logic [3:0]  f;
    logic [15:0] o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_pat = '0;
  logic [4:0]  cfg_idx = '0;
  logic [7:0]  cfg_byte = '0;
  logic [5:0]  cfg_len = '0;
  logic        cfg_nocase = 1'b0;
  logic        cfg_err;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [1:0]  m_match;
  logic [3:0]  m_first_pat;
  logic [15:0] m_offset;

  regex_lit_matcher #(.NUM_PAT(2), .PAT_LEN(8), .OFF_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_idx(cfg_idx), .cfg_byte(cfg_byte),
    .cfg_len(cfg_len), .cfg_nocase(cfg_nocase), .cfg_err(cfg_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_match(m_match),
    .m_first_pat(m_first_pat), .m_offset(m_offset)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pattern strings, current packet, expected result queue
  logic [7:0] mpat [2][8];
  int         plen [2];
  bit         pnc  [2];
  logic [7:0] pkt [$];
  res_t       exp_q [$];
  res_t       last_exp;
  res_t       last_dut;

  function automatic logic [7:0] lc(input logic [7:0] b);
    if (b >= "A" && b <= "Z") return b + 8'd32;
    return b;
  endfunction

  function automatic res_t model_eval();
    res_t r;
    bit   found;
    bit   ok;
    int   l;
    r.m = '0; r.f = '0; r.o = '0;
    found = 0;
    for (int e = 0; e < pkt.size(); e++)
      for (int p = 0; p < 2; p++) begin
        l = plen[p];
        if (l >= 1 && l <= 8 && e + 1 >= l) begin
          ok = 1;
          for (int k = 0; k < l; k++)
            if (pnc[p] ? (lc(pkt[e-l+1+k]) != lc(mpat[p][k])) : (pkt[e-l+1+k] != mpat[p][k]))
              ok = 0;
          if (ok) begin
            r.m[p] = 1'b1;
            if (!found) begin
              found = 1;
              r.f = 4'(p);
              r.o = (e > 65535) ? 16'hFFFF : 16'(e);
            end
          end
        end
      end
    return r;
  endfunction

  task automatic model_reset();
    pkt.delete();
    for (int p = 0; p < 2; p++) begin
      plen[p] = 0;
      pnc[p]  = 0;
      for (int k = 0; k < 8; k++) mpat[p][k] = '0;
    end
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    pkt.push_back(b);
    if (last) begin
      last_exp = model_eval();
      exp_q.push_back(last_exp);
      pkt.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: handshake protocol, hold stability and result contents
  bit         hold_pend = 0;
  logic [1:0] h_m;
  logic [3:0] h_f;
  logic [15:0] h_o;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_ready_rule", {31'd0, s_ready}, {31'd0, (~m_valid | m_ready)});
      if (hold_pend)
        chk("hold_stable", {11'd0, m_valid, m_match, m_first_pat, m_offset},
            {11'd0, 1'b1, h_m, h_f, h_o});
      hold_pend = m_valid && !m_ready;
      h_m = m_match; h_f = m_first_pat; h_o = m_offset;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("m_match", {30'd0, m_match}, {30'd0, e.m});
          chk("m_first_pat", {28'd0, m_first_pat}, {28'd0, e.f});
          chk("m_offset", {16'd0, m_offset}, {16'd0, e.o});
        end
        last_dut.m = m_match; last_dut.f = m_first_pat; last_dut.o = m_offset;
      end
    end else begin
      hold_pend = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int  n;
    bit  done;
    n = 0; done = 0;
    s_valid = 1'b1; s_data = b; s_last = last;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1;
      else if (++n > 50) begin
        chk("s_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    model_accept(b, last);
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic cfg_write(input int p, input int idx, input logic [7:0] b,
                           input int len, input bit nc);
    bit e;
    cfg_we = 1'b1; cfg_pat = 4'(p); cfg_idx = 5'(idx); cfg_byte = b;
    cfg_len = 6'(len); cfg_nocase = nc;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    e = (pkt.size() > 0) || (p >= 2) || (idx >= 8);
    if (!e) begin
      mpat[p][idx] = b; plen[p] = len; pnc[p] = nc;
    end
    @(negedge clk);
    chk("cfg_err", {31'd0, cfg_err}, {31'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic load_pat(input int p, input string s, input bit nc);
    for (int i = 0; i < s.len(); i++) cfg_write(p, i, s[i], s.len(), nc);
  endtask

  // Pins both the model and the DUT to a hand-computed result
  task automatic expect_lit(input string name, input logic [1:0] m, input logic [3:0] f,
                            input logic [15:0] o);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_model"}, {10'd0, last_exp.m, last_exp.f, last_exp.o}, {10'd0, m, f, o});
    chk({name, "_dut"},   {10'd0, last_dut.m, last_dut.f, last_dut.o}, {10'd0, m, f, o});
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_outs", {10'd0, m_match, m_first_pat, m_offset}, 32'd0);
    chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    load_pat(0, "Hello", 0);
    load_pat(1, "world", 1);
    send_str("xxHelloWORLD", 1);
    expect_lit("two_pat", 2'b11, 4'd0, 16'd6);

    load_pat(0, "aab", 0);
    send_str("aaab", 1);
    expect_lit("overlap", 2'b01, 4'd0, 16'd3);

    send_str("WoRlDworld", 1);
    expect_lit("nocase_p1", 2'b10, 4'd1, 16'd4);

    load_pat(0, "Hello", 0);
    send_str("Hel", 1);
    expect_lit("split_a", 2'b00, 4'd0, 16'd0);
    send_str("lo", 1);
    expect_lit("split_b", 2'b00, 4'd0, 16'd0);

    // Backpressure: result held while next byte waits
    m_ready = 1'b0;
    send_str("Hello", 1);
    s_valid = 1'b1; s_data = "x"; s_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, s_ready, m_valid}, 32'd3);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    model_accept("x", 1'b1);
    expect_lit("bp_next", 2'b00, 4'd0, 16'd0);

    // Config during a packet and out-of-range config are rejected
    send_byte("H", 1'b0);
    cfg_write(0, 0, "Z", 5, 0);
    send_str("ello", 1);
    expect_lit("cfg_locked", 2'b01, 4'd0, 16'd4);
    cfg_write(2, 0, "q", 1, 0);
    cfg_write(0, 9, "q", 1, 0);
    send_str("HELLO", 1);
    expect_lit("case_sens", 2'b00, 4'd0, 16'd0);

    // Reset mid-packet discards the packet and disables patterns
    send_str("Hel", 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_outs", {9'd0, m_valid, m_match, m_first_pat, m_offset}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    send_str("lo", 1);
    expect_lit("after_reset", 2'b00, 4'd0, 16'd0);
    send_str("Hello", 1);
    expect_lit("disabled", 2'b00, 4'd0, 16'd0);

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regex_lit_matcher.md
REGEX_LIT_MATCHER -- requirements
Module: regex_lit_matcher

Interface
REQ-001 SHALL have parameter NUM_PAT, default 4, number of independent literal patterns (1..16).
REQ-002 SHALL have parameter PAT_LEN, default 8, maximum pattern length in bytes (1..32).
REQ-003 SHALL have parameter OFF_W, default 16, width of the byte-offset counter.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  input byte valid.
REQ-007 SHALL have port s_ready  output  1  input byte accepted when s_valid & s_ready.
REQ-008 SHALL have port s_data  input  8  input byte.
REQ-009 SHALL have port s_last  input  1  marks last byte of packet.
REQ-010 SHALL have port cfg_we  input  1  config write strobe.
REQ-011 SHALL have port cfg_pat  input  4  pattern index.
REQ-012 SHALL have port cfg_idx  input  5  byte position within pattern.
REQ-013 SHALL have port cfg_byte  input  8  pattern byte value.
REQ-014 SHALL have port cfg_len  input  6  pattern length; 0 disables pattern.
REQ-015 SHALL have port cfg_nocase  input  1  case-insensitive mode for the pattern.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse: config write rejected.
REQ-017 SHALL have port m_valid  output  1  per-packet result valid.
REQ-018 SHALL have port m_ready  input  1  result consumed when m_valid & m_ready.
REQ-019 SHALL have port m_match  output  NUM_PAT  patterns matched in packet.
REQ-020 SHALL have port m_first_pat  output  4  index of first matching pattern.
REQ-021 SHALL have port m_offset  output  OFF_W  0-based offset of last byte of first match.

Function
REQ-022 SHALL hold per pattern a PAT_LEN-entry byte table, a length and a nocase bit, written by cfg_we in one cycle; cfg_we writes byte cfg_byte at cfg_idx and simultaneously updates length and nocase of cfg_pat.
REQ-023 SHALL reject cfg_we (no state change, cfg_err=1 next cycle) when a packet is in progress (at least one byte accepted, s_last not yet accepted), or cfg_pat>=NUM_PAT, or cfg_idx>=PAT_LEN.
REQ-024 SHALL treat a pattern with length 0 or length >PAT_LEN as disabled (never matches).
REQ-025 SHALL compare byte k of pattern p as eq = (s_data==pat[p][k]), or, if nocase, after folding 'A'..'Z' to 'a'..'z' on both operands.
REQ-026 SHALL keep per pattern PAT_LEN one-bit NFA states updated only on accepted bytes: st[p][0] <= eq(p,0); st[p][k] <= st[p][k-1] & eq(p,k); overlapping partial matches tracked in parallel.
REQ-027 SHALL detect hit[p] on the accepted byte when len==1 ? eq(p,0) : st[p][len-2] & eq(p,len-1).
REQ-028 SHALL accumulate hits into a sticky per-packet vector, including hits on the s_last byte.
REQ-029 SHALL record on the first hit of a packet the lowest hitting pattern index and the current byte offset; later hits do not alter them.
REQ-030 SHALL count offsets from 0 at the first byte of each packet, saturating at 2^OFF_W-1.
REQ-031 SHALL clear all NFA states, sticky vector, first-hit record and offset counter after the s_last byte is accepted; matches never span packets.
REQ-032 SHALL load m_match, m_first_pat, m_offset and assert m_valid in the cycle after s_last is accepted (latency 1); with no hits m_match=0, m_first_pat=0, m_offset=0.
REQ-033 SHALL hold m_* stable while m_valid & ~m_ready; m_valid deasserts after handshake unless a new result loads in the same cycle.
REQ-034 SHALL drive s_ready = ~m_valid | m_ready; a new result may load in the cycle the previous one is consumed.
REQ-035 SHALL ignore s_data, s_last when s_valid & s_ready is false; no state advances.

Reset
REQ-036 SHALL on rst_n low asynchronously clear: all NFA states, sticky state, counters, m_valid=0, m_match=0, m_first_pat=0, m_offset=0, cfg_err=0, all pattern lengths=0 (disabled), nocase=0.
REQ-037 SHALL on reset mid-packet discard the partial packet; no result emitted for it.

Verification
REQ-038 SHALL verify: NUM_PAT=2, p0="Hello", p1="world" nocase; packet "xxHelloWORLD" -> m_valid, m_match=2'b11, m_first_pat=0, m_offset=6.
REQ-039 SHALL verify: p0="aab", packet "aaab" -> m_match[0]=1, m_offset=3 (overlap restart).
REQ-040 SHALL verify: p0="Hello", packets "Hel"(last) then "lo"(last) -> two results, both m_match=0.
REQ-041 SHALL verify: hold m_ready=0 after result, stream next packet -> s_ready=0, m_* stable; m_ready=1 -> result consumed, byte accepted same cycle.
REQ-042 SHALL verify: cfg_we after one accepted byte of a packet -> cfg_err pulse, pattern table unchanged; p0 case-sensitive "Hello" vs "HELLO" -> no match.
REQ-043 SHALL verify: rst_n low mid-packet after "Hel", then "lo"(last) -> patterns disabled, m_match=0.
